// File: rtl/demux14_stream.sv
// demux14_stream: 1-to-4 valid/ready stream demultiplexer.
// Each input beat goes to one of four one-entry output slots. The target
// slot comes from in_sel, or from an internal round-robin pointer when
// rr_en is high. A stalled slot only blocks input beats aimed at that slot.
// An accepted-beat counter wraps silently.
module demux14_stream #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    input  logic [1:0]          in_sel,
    input  logic                rr_en,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [3:0][W-1:0]   out_data,
    output logic [1:0]          rr_ptr,
    output logic [CNT_W-1:0]    beat_cnt
);

    logic [3:0]          r_out_valid;
    logic [3:0][W-1:0]   r_out_data;
    logic [1:0]          r_rr_ptr;
    logic [CNT_W-1:0]    r_beat_cnt;

    logic [1:0]          w_sel_eff;
    logic                w_in_ready;
    logic                w_accept;
    logic [3:0]          w_load;

    // Steering decision: pick the target slot, work out whether it can take
    // a beat this cycle, and turn an accepted beat into a one-hot slot load.
    always_comb begin
        w_sel_eff  = rr_en ? r_rr_ptr : in_sel;
        w_in_ready = (!r_out_valid[w_sel_eff]) || out_ready[w_sel_eff];
        w_accept   = in_valid && w_in_ready;
        w_load     = w_accept ? (4'b0001 << w_sel_eff) : 4'b0000;
    end

    // Slot registers: a load wins over a drain, so a slot drained and
    // reloaded in one cycle stays valid and sustains one beat per cycle.
    // A drained slot keeps its last payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 4'b0000;
            r_out_data  <= {(4*W){1'b0}};
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_out_valid[k] <= 1'b1;
                    r_out_data[k]  <= in_data;
                end else if (r_out_valid[k] && out_ready[k]) begin
                    r_out_valid[k] <= 1'b0;
                end else begin
                    r_out_valid[k] <= r_out_valid[k];
                end
            end
        end
    end

    // Round-robin pointer advances only on beats it actually steered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= 2'd0;
        end else if (w_accept && rr_en) begin
            r_rr_ptr <= r_rr_ptr + 2'd1;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // Accepted-beat counter, counts in both steering modes, wraps to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat_cnt <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_beat_cnt <= r_beat_cnt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign rr_ptr    = r_rr_ptr;
    assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_demux14_stream.sv
// Scoreboard bench for demux14_stream: directed beats push the hand-chosen
// target channel and payload into per-channel queues; a monitor pops and
// compares whenever a channel completes a handshake.
module tb_demux14_stream;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic [1:0]        in_sel;
    logic              rr_en;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [3:0][7:0]   out_data;
    logic [1:0]        rr_ptr;
    logic [15:0]       beat_cnt;

    logic              w4_in_ready;
    logic [3:0]        w4_out_valid;
    logic [3:0][7:0]   w4_out_data;
    logic [1:0]        w4_rr_ptr;
    logic [3:0]        w4_beat_cnt;

    int checks;
    int errors;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] q3[$];

    demux14_stream #(.W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .rr_en(rr_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rr_ptr(rr_ptr), .beat_cnt(beat_cnt)
    );

    demux14_stream #(.W(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w4_in_ready),
        .in_data(in_data), .in_sel(in_sel), .rr_en(rr_en),
        .out_valid(w4_out_valid), .out_ready(out_ready), .out_data(w4_out_data),
        .rr_ptr(w4_rr_ptr), .beat_cnt(w4_beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] ch, input logic [7:0] d);
        case (ch)
            2'd0: q0.push_back(d);
            2'd1: q1.push_back(d);
            2'd2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic flush_exp();
        q0.delete();
        q1.delete();
        q2.delete();
        q3.delete();
    endtask

    // Monitor: every completed output handshake must match the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    logic [7:0] e;
                    int sz;
                    case (k)
                        0: sz = q0.size();
                        1: sz = q1.size();
                        2: sz = q2.size();
                        default: sz = q3.size();
                    endcase
                    checks++;
                    if (sz == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat ch%0d: got %0h expected none", k, out_data[k]);
                    end else begin
                        case (k)
                            0: e = q0.pop_front();
                            1: e = q1.pop_front();
                            2: e = q2.pop_front();
                            default: e = q3.pop_front();
                        endcase
                        if (out_data[k] !== e) begin
                            errors++;
                            $display("FAIL out_data ch%0d: got %0h expected %0h", k, out_data[k], e);
                        end
                    end
                end
            end
        end
    end

    // Present one beat (called just after a rising edge); returns just after
    // the edge that accepted it. exp_ch is the hand-computed target slot.
    task automatic beat(input logic [1:0] sel, input logic [7:0] d,
                        input logic [1:0] exp_ch, input bit must_now);
        int waited;
        bit done;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        waited   = 0;
        done     = 1'b0;
        while (!done && waited < 20) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(exp_ch, d);
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept of %0h", d);
        end else if (must_now) begin
            chk("accept_wait_cycles", waited, 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush_exp();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sel    = 2'd0;
        rr_en     = 1'b0;
        out_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 4'b0000);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_rr_ptr", rr_ptr, 2'd0);
        chk("reset_beat_cnt", beat_cnt, 16'd0);
        chk("reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // 1: steered beat to channel 2
        beat(2'd2, 8'hA5, 2'd2, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("steer_out_valid", out_valid, 4'b0100);
        chk("steer_out_data2", out_data[2], 8'hA5);
        chk("steer_beat_cnt", beat_cnt, 16'd1);
        @(posedge clk);
        #1;

        // 2: backpressure on channel 1, channel 0 still flows
        out_ready = 4'b1101;
        beat(2'd1, 8'h11, 2'd1, 1'b1);
        in_sel   = 2'd1;
        in_data  = 8'h22;
        in_valid = 1'b1;
        #2;
        chk("bp_in_ready_blocked", in_ready, 1'b0);
        beat(2'd0, 8'h33, 2'd0, 1'b1);
        in_sel  = 2'd1;
        in_data = 8'h22;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("bp_hold_valid1", out_valid[1], 1'b1);
        chk("bp_hold_data1", out_data[1], 8'h11);
        chk("bp_still_blocked", in_ready, 1'b0);
        out_ready = 4'hF;
        beat(2'd1, 8'h22, 2'd1, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_release_valid1", out_valid[1], 1'b1);
        chk("bp_release_data1", out_data[1], 8'h22);
        chk("bp_beat_cnt", beat_cnt, 16'd4);
        @(posedge clk);
        #1;

        // 3: round-robin from a clean reset, five back-to-back beats
        do_reset();
        rr_en = 1'b1;
        beat(2'd3, 8'h51, 2'd0, 1'b1);
        beat(2'd3, 8'h52, 2'd1, 1'b1);
        beat(2'd0, 8'h53, 2'd2, 1'b1);
        beat(2'd0, 8'h54, 2'd3, 1'b1);
        beat(2'd2, 8'h55, 2'd0, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rr_ptr_end", rr_ptr, 2'd1);
        chk("rr_beat_cnt", beat_cnt, 16'd5);
        chk("rr_last_valid", out_valid, 4'b0001);
        @(posedge clk);
        #1;

        // 4: full throughput on channel 3
        rr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat(2'd3, 8'h80 + 8'(i), 2'd3, 1'b1);
            #1;
            chk("tput_valid3", out_valid[3], 1'b1);
            chk("tput_data3", out_data[3], 8'h80 + 8'(i));
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("tput_rr_hold", rr_ptr, 2'd1);
        chk("tput_beat_cnt", beat_cnt, 16'd13);
        @(posedge clk);
        #1;

        // 5: reset while slots 0 and 2 are occupied
        out_ready = 4'b0000;
        beat(2'd0, 8'hC0, 2'd0, 1'b1);
        beat(2'd2, 8'hC2, 2'd2, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", out_valid, 4'b0101);
        #2;
        reset = 1'b1;
        flush_exp();
        #1;
        chk("midreset_out_valid", out_valid, 4'b0000);
        chk("midreset_rr_ptr", rr_ptr, 2'd0);
        chk("midreset_beat_cnt", beat_cnt, 16'd0);
        chk("midreset_out_data2", out_data[2], 8'h00);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b1;
        in_sel   = 2'd0;
        #1;
        chk("postreset_in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // 6: counter wrap on the 4-bit counter instance
        do_reset();
        out_ready = 4'hF;
        for (int i = 0; i < 17; i++) begin
            beat(2'(i), 8'(i), 2'(i), 1'b1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_cnt4", w4_beat_cnt, 4'd1);
        chk("wrap_cnt16", beat_cnt, 16'd17);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", q0.size() + q1.size() + q2.size() + q3.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
